insn_frame_loader: RTL and testbench

INSN_FRAME_LOADER -- requirements
Module: insn_frame_loader

---
 rtl/insn_frame_loader_pkg.sv | 28 ++
 rtl/insn_frame_mem.sv | 39 +++
 rtl/insn_frame_loader.sv | 186 ++++++++++++++++++
 tb/tb_insn_frame_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : insn_frame_loader_pkg
// Description : Shared ranges for the instruction frame loader. This package
//               holds the default frame geometry, the memory depth, the R0
//               width, the loader state encoding, and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package insn_frame_loader_pkg;

  localparam int c_INSN_LOAD_TIME = 4;   // parts per instruction frame
  localparam int c_INSN_BUS_W     = 32;  // width of one frame part
  localparam int c_IMEM_DEPTH     = 16;  // frames in local instruction memory
  localparam int c_REG_W          = 8;   // width of R0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2
  } loader_state_t;

  // Index width that never collapses to zero bits, e.g. for a one-part frame.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/insn_frame_mem.sv
`default_nettype none
// ============================================================================
// Module      : insn_frame_mem
// Description : Local instruction memory. It has one write port that stores a
//               full frame and one combinational read port. The contents are
//               not reset.
// Ports       : clk        - clock, rising edge
//               i_wr_en    - write the frame on i_wr_data to i_wr_addr
//               i_wr_addr  - frame slot to write
//               i_wr_data  - assembled frame
//               i_rd_addr  - frame slot to read
//               o_rd_data  - frame at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module insn_frame_mem #(
  parameter int DEPTH   = 16,
  parameter int FRAME_W = 128,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [FRAME_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [FRAME_W-1:0] o_rd_data
);

  logic [FRAME_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/insn_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : insn_frame_loader
// Description : Collects one instruction frame from the scheduler bus, one
//               part per cycle. It stores the completed frame in local
//               memory, then hands the frame to the execution core and waits
//               for core_done.
// Ports       : clk, reset        - clock; asynchronous active-high reset
//               start             - this core's Start bit (part is valid)
//               insn_load_counter - index of the part on insn_data
//               insn_data         - frame part
//               init_r0_en/init_r0- optional R0 preload with the frame
//               ready             - 1 while idle or loading
//               core_run          - one-cycle launch pulse to the core
//               core_done         - core finished the current frame
//               imem_rd_addr/data - combinational frame read port
//               run_addr          - memory slot of the frame being run
//               r0_value/r0_valid - preloaded R0 and its valid flag
//               proto_err         - sticky bus protocol violation
//               overflow          - sticky: a write used the last slot
// Revision    : 1.0 - initial release
// ============================================================================
module insn_frame_loader
  import insn_frame_loader_pkg::*;
#(
  parameter int INSN_LOAD_TIME = c_INSN_LOAD_TIME,
  parameter int INSN_BUS_W     = c_INSN_BUS_W,
  parameter int IMEM_DEPTH     = c_IMEM_DEPTH,
  parameter int REG_W          = c_REG_W,
  localparam int CNT_W   = safe_clog2(INSN_LOAD_TIME),
  localparam int ADDR_W  = safe_clog2(IMEM_DEPTH),
  localparam int FRAME_W = INSN_LOAD_TIME * INSN_BUS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   insn_load_counter,
  input  logic [INSN_BUS_W-1:0] insn_data,
  input  logic               init_r0_en,
  input  logic [REG_W-1:0]   init_r0,
  output logic               ready,
  output logic               core_run,
  input  logic               core_done,
  input  logic [ADDR_W-1:0]  imem_rd_addr,
  output logic [FRAME_W-1:0] imem_rd_data,
  output logic [ADDR_W-1:0]  run_addr,
  output logic [REG_W-1:0]   r0_value,
  output logic               r0_valid,
  output logic               proto_err,
  output logic               overflow
);

  loader_state_t           r_state, w_next_state;
  logic [INSN_BUS_W-1:0]   r_slot [INSN_LOAD_TIME];
  logic [CNT_W-1:0]        r_exp;
  logic [ADDR_W-1:0]       r_wr_ptr, r_run_addr;
  logic [REG_W-1:0]        r_r0_value;
  logic                    r_r0_valid, r_proto_err, r_overflow, r_core_run;

  logic                    w_capture, w_complete, w_err, w_is_last;
  logic [FRAME_W-1:0]      w_frame;

  assign w_is_last = (insn_load_counter == CNT_W'(INSN_LOAD_TIME - 1));

  // Next state and per-cycle events. A capture of the last part completes
  // the frame. For a one-part frame, this can happen straight from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_complete   = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (insn_load_counter == '0) begin
            w_capture    = 1'b1;
            w_complete   = w_is_last;
            w_next_state = w_is_last ? ST_EXEC : ST_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (start && (insn_load_counter == r_exp)) begin
          w_capture    = 1'b1;
          w_complete   = w_is_last;
          w_next_state = w_is_last ? ST_EXEC : ST_LOAD;
        end else begin
          // The bus broke the sequence. The partial frame is dropped.
          w_err        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // The scheduler must not start a new frame while the core runs.
        w_err = start;
        if (core_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The memory is written on the same edge as the last part. The frame is
  // therefore assembled from the stored slots plus the live bus part.
  for (genvar gi = 0; gi < INSN_LOAD_TIME; gi++) begin : g_frame
    if (gi == INSN_LOAD_TIME - 1) begin : g_last
      assign w_frame[gi*INSN_BUS_W +: INSN_BUS_W] = insn_data;
    end else begin : g_slot
      assign w_frame[gi*INSN_BUS_W +: INSN_BUS_W] = r_slot[gi];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INSN_LOAD_TIME; i++) begin
        r_slot[i] <= '0;
      end
      r_exp       <= '0;
      r_wr_ptr    <= '0;
      r_run_addr  <= '0;
      r_r0_value  <= '0;
      r_r0_valid  <= 1'b0;
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_core_run  <= 1'b0;
    end else begin
      r_core_run <= w_complete;
      if (w_capture) begin
        r_slot[insn_load_counter] <= insn_data;
        r_exp                     <= insn_load_counter + CNT_W'(1);
      end
      if (w_complete) begin
        r_run_addr <= r_wr_ptr;
        if (r_wr_ptr == ADDR_W'(IMEM_DEPTH - 1)) begin
          r_wr_ptr   <= '0;
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
        // R0 validity follows each launched frame. A frame without a
        // preload clears the flag at the moment its core_run is issued.
        r_r0_valid <= init_r0_en;
        if (init_r0_en) begin
          r_r0_value <= init_r0;
        end
      end
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  insn_frame_mem #(
    .DEPTH   (IMEM_DEPTH),
    .FRAME_W (FRAME_W),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_complete),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_frame),
    .i_rd_addr (imem_rd_addr),
    .o_rd_data (imem_rd_data)
  );

  assign ready     = (r_state != ST_EXEC);
  assign core_run  = r_core_run;
  assign run_addr  = r_run_addr;
  assign r0_value  = r_r0_value;
  assign r0_valid  = r_r0_valid;
  assign proto_err = r_proto_err;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_insn_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_frame_loader
// Description : Directed self-checking bench for insn_frame_loader. Each
//               completed frame pushes its expected contents and memory slot
//               onto a scoreboard. The entry is popped and compared when
//               core_run fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_frame_loader;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int D  = 16;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      insn_load_counter;
  logic [BW-1:0]   insn_data;
  logic            init_r0_en;
  logic [RW-1:0]   init_r0;
  logic            ready, core_run, core_done;
  logic [3:0]      imem_rd_addr;
  logic [N*BW-1:0] imem_rd_data;
  logic [3:0]      run_addr;
  logic [RW-1:0]   r0_value;
  logic            r0_valid, proto_err, overflow;

  typedef struct {
    logic [N*BW-1:0] frame;
    logic [3:0]      addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [3:0]  m_wr_ptr;
  logic        m_ovf, m_proto, m_r0_valid;
  logic [7:0]  m_r0_value;

  always #5 clk = ~clk;

  insn_frame_loader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .insn_load_counter (insn_load_counter),
    .insn_data         (insn_data),
    .init_r0_en        (init_r0_en),
    .init_r0           (init_r0),
    .ready             (ready),
    .core_run          (core_run),
    .core_done         (core_done),
    .imem_rd_addr      (imem_rd_addr),
    .imem_rd_data      (imem_rd_data),
    .run_addr          (run_addr),
    .r0_value          (r0_value),
    .r0_valid          (r0_valid),
    .proto_err         (proto_err),
    .overflow          (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_ptr   = '0;
    m_ovf      = 1'b0;
    m_proto    = 1'b0;
    m_r0_valid = 1'b0;
    m_r0_value = '0;
  endtask

  // Wait (bounded) for the launch pulse, then check the frame it launched.
  task automatic check_run(input string tag);
    exp_t e;
    int   n = 0;
    while (core_run !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    chk({tag, "_core_run"}, core_run, 1'b1);
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_run_addr"}, run_addr, e.addr);
    imem_rd_addr = e.addr;
    #1;
    chk({tag, "_imem"}, imem_rd_data, e.frame);
    chk({tag, "_ready_exec"}, ready, 1'b0);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_r0_valid"}, r0_valid, m_r0_valid);
    chk({tag, "_r0_value"}, r0_value, m_r0_value);
    chk({tag, "_proto_err"}, proto_err, m_proto);
    step();
    chk({tag, "_run_pulse_end"}, core_run, 1'b0);
    chk({tag, "_still_exec"}, ready, 1'b0);
  endtask

  task automatic load_frame(input string tag, input logic [7:0] id,
                            input logic r0en, input logic [7:0] r0v);
    logic [N*BW-1:0] f;
    logic [BW-1:0]   d;
    exp_t            e;
    for (int i = 0; i < N; i++) begin
      d = {id, 8'(i), 16'($urandom)};
      f[i*BW +: BW] = d;
      start = 1'b1;
      insn_load_counter = 2'(i);
      insn_data  = d;
      init_r0_en = r0en;
      init_r0    = r0v;
      if (i == N - 1) begin
        e.frame = f;
        e.addr  = m_wr_ptr;
        sb_q.push_back(e);
      end
      step();
      if (i < N - 1) chk({tag, "_ready_load"}, ready, 1'b1);
    end
    start      = 1'b0;
    init_r0_en = 1'b0;
    if (m_wr_ptr == 4'(D - 1)) m_ovf = 1'b1;
    m_wr_ptr   = m_wr_ptr + 4'd1;
    m_r0_valid = r0en;
    if (r0en) m_r0_value = r0v;
    check_run(tag);
  endtask

  task automatic finish_exec(input string tag, input logic with_start);
    core_done = 1'b1;
    start = with_start;
    insn_load_counter = '0;
    step();
    core_done = 1'b0;
    start = 1'b0;
    if (with_start) m_proto = 1'b1;
    chk({tag, "_idle"}, ready, 1'b1);
    chk({tag, "_proto_err"}, proto_err, m_proto);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; insn_load_counter = '0; insn_data = '0;
    init_r0_en = 1'b0; init_r0 = '0; core_done = 1'b0; imem_rd_addr = '0;
    model_reset();
    step(); step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_run_addr", run_addr, 4'd0);
    chk("rst_r0_value", r0_value, 8'd0);
    chk("rst_r0_valid", r0_valid, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    step();

    // Start is dropped after part 1. The partial frame must not advance
    // wr_ptr, so frame A below must land in slot 0.
    start = 1'b1; insn_load_counter = 2'd0; insn_data = 32'hDEAD0000; step();
    insn_load_counter = 2'd1; insn_data = 32'hDEAD0001; step();
    start = 1'b0; step();
    m_proto = 1'b1;
    chk("drop_proto_err", proto_err, 1'b1);
    chk("drop_idle", ready, 1'b1);
    chk("drop_no_run", core_run, 1'b0);

    load_frame("frmA", 8'hA0, 1'b0, 8'h00);
    finish_exec("frmA_done", 1'b0);
    load_frame("frmB", 8'hB0, 1'b1, 8'h5A);
    finish_exec("frmB_done", 1'b0);
    load_frame("frmC", 8'hC0, 1'b0, 8'h00);
    finish_exec("frmC_done", 1'b0);

    // Reset arrives while part 2 is on the bus. It takes effect at once.
    start = 1'b1; insn_load_counter = 2'd0; insn_data = 32'h0BAD0000; step();
    insn_load_counter = 2'd1; insn_data = 32'h0BAD0001; step();
    insn_load_counter = 2'd2; insn_data = 32'h0BAD0002;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_proto_err", proto_err, 1'b0);
    chk("midrst_r0_value", r0_value, 8'd0);
    chk("midrst_run_addr", run_addr, 4'd0);
    step();
    reset = 1'b0; start = 1'b0;
    step();

    // Clean frame after reset: it lands in slot 0. It then exits EXEC with
    // start and core_done high together.
    load_frame("frmD", 8'hD0, 1'b0, 8'h00);
    finish_exec("start_done", 1'b1);

    // Fill the remaining 15 slots. The 16th write sets overflow.
    for (int k = 1; k < D; k++) begin
      load_frame("fill", 8'(k), 1'b0, 8'h00);
      finish_exec("fill_done", 1'b0);
    end
    chk("fill_overflow", overflow, 1'b1);
    load_frame("wrap", 8'hEE, 1'b0, 8'h00);
    finish_exec("wrap_done", 1'b0);

    // Start alone in EXEC: flag an error but keep running.
    reset = 1'b1; step(); reset = 1'b0; model_reset(); step();
    load_frame("frmE", 8'hE0, 1'b0, 8'h00);
    start = 1'b1; insn_load_counter = '0; step(); start = 1'b0;
    m_proto = 1'b1;
    chk("exec_start_proto", proto_err, 1'b1);
    chk("exec_start_busy", ready, 1'b0);
    chk("exec_start_no_run", core_run, 1'b0);
    finish_exec("frmE_done", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
